// File: rtl/sysbus_mem_responder_if.sv
// SysBus view between the CPU datapath (master) and the memory responder (slave).
interface sysbus_mem_responder_if;
  logic [15:0] SysBus;
  logic        Ale;
  logic        ReadReq;
  logic        WriteReq;
  logic [15:0] DataIn;
  logic        Ready;
  logic        Busy;
  logic        AddrErr;

  modport master (
    output SysBus, Ale, ReadReq, WriteReq,
    input  DataIn, Ready, Busy, AddrErr
  );

  modport slave (
    input  SysBus, Ale, ReadReq, WriteReq,
    output DataIn, Ready, Busy, AddrErr
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Memory-side SysBus responder: latches an address, then serves one read or
// write per request against a word-addressed RAM after WAIT_STATES cycles.
module sysbus_mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  sysbus_mem_responder_if.slave  bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_BITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_next_count;
  logic                w_accept;

  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_write;
  logic [DATA_W-1:0]   r_data_in;
  logic                r_ready;
  logic                r_busy;
  logic                r_addr_err;

  logic                w_in_range;
  logic [ADDR_BITS-1:0] w_idx;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  assign w_in_range = ((r_addr >> ADDR_BITS) == '0);
  assign w_idx      = r_addr[ADDR_BITS-1:0];

  // State and wait counter register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  // Next-state logic; Ale in IDLE blocks acceptance for that cycle
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.Ale && (bus.ReadReq || bus.WriteReq)) begin
          w_accept = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next_state = S_ACCESS;
          end else begin
            w_next_state = S_WAIT;
            w_next_count = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_count == '0) begin
          w_next_state = S_ACCESS;
        end else begin
          w_next_count = r_count - CNT_W'(1);
        end
      end
      S_ACCESS: w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Registered bus outputs, address/write-data capture and read return
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_data_in  <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_busy     <= (w_next_state != S_IDLE);
      r_ready    <= (w_next_state == S_DONE);
      r_addr_err <= (r_state == S_ACCESS) && !w_in_range;
      if ((r_state == S_IDLE) && bus.Ale) begin
        r_addr <= bus.SysBus;
      end
      if (w_accept) begin
        r_is_write <= bus.WriteReq;
        if (bus.WriteReq) begin
          r_wdata <= bus.SysBus;
        end
      end
      if ((r_state == S_ACCESS) && !r_is_write) begin
        r_data_in <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  // RAM write port; reset wins over a write in the ACCESS cycle
  always_ff @(posedge Clock) begin
    if (!Reset && (r_state == S_ACCESS) && r_is_write && w_in_range) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.DataIn  = r_data_in;
  assign bus.Ready   = r_ready;
  assign bus.Busy    = r_busy;
  assign bus.AddrErr = r_addr_err;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: dut_a uses 2 wait states,
// dut_b uses 0 wait states. Drivers push expected responses; a monitor
// pops and compares on every Ready pulse, including the Ready cycle number.
module tb_sysbus_mem_responder;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [15:0] last_rd [2];

  sysbus_mem_responder_if if_a ();
  sysbus_mem_responder_if if_b ();

  sysbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(2)) u_dut_a (
    .Clock (clk),
    .Reset (rst),
    .bus   (if_a)
  );

  sysbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) u_dut_b (
    .Clock (clk),
    .Reset (rst),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic ale, input logic rd, input logic wr,
                       input logic [15:0] bus);
    if (sel) begin
      if_b.Ale = ale; if_b.ReadReq = rd; if_b.WriteReq = wr; if_b.SysBus = bus;
    end else begin
      if_a.Ale = ale; if_a.ReadReq = rd; if_a.WriteReq = wr; if_a.SysBus = bus;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? if_b.Ready : if_a.Ready;
  endfunction

  // Monitor side: one scoreboard pop per Ready pulse
  task automatic score(input bit sel);
    exp_t        e;
    string       nm;
    logic [15:0] d;
    logic        er;
    nm = sel ? "b" : "a";
    d  = sel ? if_b.DataIn : if_a.DataIn;
    er = sel ? if_b.AddrErr : if_a.AddrErr;
    if ((sel && q_b.size() == 0) || (!sel && q_a.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_unexpected_ready: got Ready=1 expected none (cycle %0d)", nm, cyc);
      return;
    end
    if (sel) e = q_b.pop_front();
    else     e = q_a.pop_front();
    chk({nm, "_data"},        32'(d),     32'(e.data));
    chk({nm, "_addr_err"},    32'(er),    32'(e.err));
    chk({nm, "_ready_cycle"}, 32'(cyc),   32'(e.cyc));
  endtask

  always @(negedge clk) begin
    if (if_a.Ready) score(1'b0);
    if (if_b.Ready) score(1'b1);
  end

  // Drive-point tasks start and end at #1 after a rising edge
  task automatic latch(input bit sel, input logic [15:0] addr);
    drive(sel, 1'b1, 1'b0, 1'b0, addr);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic request(input bit sel, input logic wr, input logic rd,
                         input logic [15:0] data, input logic [15:0] exp_data,
                         input logic exp_err, input bit busy_ale);
    exp_t e;
    int   ws;
    bit   got;
    ws     = sel ? 0 : 2;
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc + ws + 2;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    drive(sel, 1'b0, rd, wr, wr ? data : 16'h0000);
    @(posedge clk); #1;
    if (busy_ale) begin
      drive(sel, 1'b1, rd, wr, 16'h0006);
      @(posedge clk); #1;
      drive(sel, 1'b0, rd, wr, 16'h0000);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy(sel)) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got no Ready expected Ready within 20 cycles (cycle %0d)", cyc);
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
  endtask

  task automatic wr_txn(input bit sel, input logic [15:0] addr, input logic [15:0] data,
                        input logic err);
    latch(sel, addr);
    request(sel, 1'b1, 1'b0, data, last_rd[sel], err, 1'b0);
  endtask

  task automatic rd_txn(input bit sel, input logic [15:0] addr, input logic [15:0] exp,
                        input logic err);
    latch(sel, addr);
    request(sel, 1'b0, 1'b1, 16'h0000, exp, err, 1'b0);
    last_rd[sel] = exp;
  endtask

  // Write accepted on dut_a, then reset d cycles after acceptance
  task automatic abort_write(input logic [15:0] addr, input logic [15:0] data, input int d);
    latch(1'b0, addr);
    drive(1'b0, 1'b0, 1'b0, 1'b1, data);
    @(posedge clk); #1;
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    chk("abort_busy",    32'(if_a.Busy),   32'h0);
    chk("abort_ready",   32'(if_a.Ready),  32'h0);
    chk("abort_data_in", 32'(if_a.DataIn), 32'h0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_in",  32'(if_a.DataIn),  32'h0);
    chk("rst_ready",    32'(if_a.Ready),   32'h0);
    chk("rst_busy",     32'(if_a.Busy),    32'h0);
    chk("rst_addr_err", 32'(if_a.AddrErr), 32'h0);
    chk("rst_b_busy",   32'(if_b.Busy),    32'h0);
    @(posedge clk); #1;

    // Zero wait states: Ready two cycles after acceptance
    wr_txn(1'b1, 16'h0000, 16'h1234, 1'b0);
    rd_txn(1'b1, 16'h0000, 16'h1234, 1'b0);

    // Write then read back
    wr_txn(1'b0, 16'h0005, 16'hBEEF, 1'b0);
    rd_txn(1'b0, 16'h0005, 16'hBEEF, 1'b0);

    // Out of range: write suppressed, read returns zero
    wr_txn(1'b0, 16'h0000, 16'h0F0F, 1'b0);
    wr_txn(1'b0, 16'h0400, 16'hAAAA, 1'b1);
    rd_txn(1'b0, 16'h0000, 16'h0F0F, 1'b0);
    rd_txn(1'b0, 16'h0400, 16'h0000, 1'b1);

    // Ale and ReadReq together: accepted one cycle later at the new address
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005);
    @(posedge clk); #1;
    request(1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    last_rd[0] = 16'hBEEF;

    // Both requests high: the write wins, DataIn untouched
    latch(1'b0, 16'h0006);
    request(1'b0, 1'b1, 1'b1, 16'h7777, 16'hBEEF, 1'b0, 1'b0);
    rd_txn(1'b0, 16'h0006, 16'h7777, 1'b0);

    // Ale while busy is ignored; address stays 0x0005 for the next read
    latch(1'b0, 16'h0005);
    request(1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    request(1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    last_rd[0] = 16'hBEEF;

    // Reset during WAIT and during ACCESS of a write: RAM keeps old value
    wr_txn(1'b0, 16'h0010, 16'h1111, 1'b0);
    abort_write(16'h0010, 16'h5555, 0);
    rd_txn(1'b0, 16'h0010, 16'h1111, 1'b0);
    abort_write(16'h0010, 16'h5555, 2);
    rd_txn(1'b0, 16'h0010, 16'h1111, 1'b0);
    rd_txn(1'b0, 16'h0005, 16'hBEEF, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("a_pending", 32'(q_a.size()), 32'h0);
    chk("b_pending", 32'(q_b.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
Memory-side responder for the CPU datapath's SysBus protocol. It latches an address from SysBus, then serves one read or one write per request against an internal word-addressed RAM. Each access takes a configurable number of wait states and finishes with a Ready pulse. Read data is returned on DataIn, which the datapath drives onto SysBus when MemEn is high.

Parameters:
ADDR_BITS, 10, RAM depth is 2**ADDR_BITS 16-bit words.
WAIT_STATES, 2, wait cycles inserted between request acceptance and array access (legal range 0..15).

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
SysBus  input  16  shared bus as seen by the responder; carries the address when Ale=1 and write data when WriteReq=1.
Ale  input  1  address latch enable; captures SysBus into the address register.
ReadReq  input  1  read request level; held by the master until Ready.
WriteReq  input  1  write request level; SysBus holds write data in the acceptance cycle.
DataIn  output  16  read data toward the datapath DataIn input.
Ready  output  1  one-cycle completion pulse.
Busy  output  1  high in every state except IDLE.
AddrErr  output  1  out-of-range flag; only valid while Ready=1.

Behaviour:
- Reset (synchronous, Clock edge with Reset=1):
  - state=IDLE.
  - Address register, write-data register and DataIn cleared to 16'h0000.
  - Ready, AddrErr and Busy cleared to 0.
  - RAM contents are not cleared.
- Reset mid-transaction: the transaction is aborted and no RAM write occurs. This holds even if reset is asserted in the ACCESS cycle, because reset has priority over the write.
- Address latch:
  - Ale=1 in IDLE loads SysBus into Addr.
  - Ale is ignored in all other states.
  - Ale and a request in the same IDLE cycle: the address is latched and the request is ignored that cycle. A request still held next cycle is then accepted.
- State machine:
  - IDLE:
    - ReadReq=1 or WriteReq=1 (and Ale=0) accepts the request.
    - If both requests are high, the write wins.
    - For a write, SysBus is captured into the write-data register in this cycle.
    - Next state: WAIT with Count=WAIT_STATES-1, or ACCESS if WAIT_STATES=0.
  - WAIT: if Count==0 go to ACCESS, else decrement Count. WAIT lasts exactly WAIT_STATES cycles.
  - ACCESS:
    - In range (Addr[15:ADDR_BITS]==0): a write updates RAM[Addr[ADDR_BITS-1:0]]; a read loads DataIn from RAM.
    - Out of range: writes are suppressed and a read loads DataIn=16'h0000.
    - Next state: DONE.
  - DONE: Ready=1 for this cycle only, AddrErr=range error of this transaction, then go to IDLE.
- Latency: a request accepted in cycle k produces Ready in cycle k+WAIT_STATES+2. For a read, DataIn is valid in the Ready cycle.
- DataIn holds its value until the next read reaches ACCESS; writes do not change DataIn.
- Requests and Ale arriving while Busy=1 are ignored; request level changes mid-transaction have no effect.
- The master must drop its request in the Ready cycle. A request still high in the following IDLE cycle starts a new transaction, so back-to-back accesses are legal with one IDLE cycle between them.
- Read-after-write to the same address returns the newly written data; there is no hazard because the transactions are serialized.
- Address is word-granular; there is no byte enable.

Test Plan:
- Reset check: reset asserted for 2 cycles, then released -> DataIn=0000, Ready=0, Busy=0, AddrErr=0.
- Write then read:
  - Ale with SysBus=0x0005, then WriteReq with SysBus=0xBEEF -> Ready 4 cycles after acceptance, AddrErr=0.
  - Then ReadReq at 0x0005 -> Ready with DataIn=0xBEEF.
- Zero wait states: WAIT_STATES=0, read of a preloaded word 0x1234 at 0x0000 -> Ready exactly 2 cycles after acceptance, DataIn=0x1234.
- Out of range:
  - Ale with SysBus=0x0400, write 0xAAAA -> Ready with AddrErr=1 and RAM[0] unchanged.
  - Read at 0x0400 -> DataIn=0x0000, AddrErr=1.
- Collisions:
  - Ale and ReadReq in the same cycle -> no acceptance that cycle; accepted the next cycle using the new address.
  - ReadReq and WriteReq both high -> a write is performed.
  - Ale while Busy -> Addr unchanged.
- Reset mid-write: Reset asserted during WAIT of a write of 0x5555 to 0x0010 -> returns to IDLE, no Ready pulse, RAM[0x10] keeps its old value.
